// File: rtl/sdf_r2_stage.sv
// Radix-2 SDF FFT stage: DEPTH-entry feedback delay line around a butterfly, sums then differences.
// Latency: one cycle from an accepting step to the registered output.
// Backpressure: no downstream stall; in_ready drops only while flushing pending differences (DRAIN).
module sdf_r2_stage #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    input  logic             drain,
    output logic             out_valid,
    output logic             out_sop,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im
);
    localparam int CW = $clog2(2 * DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {FILL, CALC, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             pending, pending_nxt;
    logic [PW-1:0]    ptr;
    logic [2*WIDTH-1:0] line [2**PW];
    logic [WIDTH-1:0] head_re, head_im;
    logic [WIDTH-1:0] sum_re, sum_im, diff_re, diff_im;
    logic [WIDTH-1:0] push_re, push_im, res_re, res_im;
    logic             res_vld, res_sop;
    logic             step;

    // Keep the sign, drop bit WIDTH-1: magnitude overflow wraps instead of saturating.
    function automatic logic [WIDTH-1:0] bfly_wrap(input logic [WIDTH:0] r);
        return {r[WIDTH], r[WIDTH-2:0]};
    endfunction

    assign in_ready = (state != DRAIN);
    assign step     = (in_valid & in_ready) | (state == DRAIN);
    assign {head_re, head_im} = line[ptr];

    always_comb begin
        sum_re  = bfly_wrap({head_re[WIDTH-1], head_re} + {in_re[WIDTH-1], in_re});
        sum_im  = bfly_wrap({head_im[WIDTH-1], head_im} + {in_im[WIDTH-1], in_im});
        diff_re = bfly_wrap({head_re[WIDTH-1], head_re} - {in_re[WIDTH-1], in_re});
        diff_im = bfly_wrap({head_im[WIDTH-1], head_im} - {in_im[WIDTH-1], in_im});
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = step ? cnt + CW'(1) : cnt;
        pending_nxt = pending;
        push_re     = in_re;
        push_im     = in_im;
        res_re      = head_re;
        res_im      = head_im;
        res_vld     = 1'b0;
        res_sop     = 1'b0;
        case (state)
            FILL: begin
                res_vld = pending;
                if (step && cnt == CW'(DEPTH - 1)) begin
                    state_nxt   = CALC;
                    pending_nxt = 1'b0;
                end else if (!in_valid && drain && pending && cnt == '0) begin
                    state_nxt = DRAIN;
                end
            end
            CALC: begin
                push_re = diff_re;
                push_im = diff_im;
                res_re  = sum_re;
                res_im  = sum_im;
                res_vld = 1'b1;
                res_sop = (cnt == CW'(DEPTH));
                if (step && cnt == CW'(2 * DEPTH - 1)) begin
                    state_nxt   = FILL;
                    pending_nxt = 1'b1;
                end
            end
            DRAIN: begin
                // Zeros are pushed so the line never replays a flushed block.
                push_re = '0;
                push_im = '0;
                res_vld = 1'b1;
                if (cnt == CW'(DEPTH - 1)) begin
                    state_nxt   = FILL;
                    cnt_nxt     = '0;
                    pending_nxt = 1'b0;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            pending   <= 1'b0;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pending   <= pending_nxt;
            out_valid <= step & res_vld;
            out_sop   <= step & res_sop;
            if (step && res_vld) begin
                out_re <= res_re;
                out_im <= res_im;
            end
            if (step) begin
                ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
            end
        end
    end

    // Line contents survive reset; pending gates any stale entries from being emitted.
    always_ff @(posedge clk) begin
        if (step) begin
            line[ptr] <= {push_re, push_im};
        end
    end
endmodule
